// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program-counter sequencer
package pc_pkg;

  // Width of the program counter and the fetch address bus
  localparam int PC_W = 8;

  typedef logic [PC_W-1:0] pc_t;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

  // Sequential step; the PC wraps modulo 2^PC_W
  localparam pc_t INC       = 8'd4;
  // PC loaded when reset is asserted
  localparam pc_t RESET_VEC = 8'h00;
  // PC loaded on a trap or on a redirect to a misaligned target
  localparam pc_t TRAP_VEC  = 8'hF0;

  // Instructions are word aligned: the two low address bits must be zero
  function automatic logic is_aligned(input pc_t addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC priority mux: trap, redirect, then sequential
module pc_next_sel
  import pc_pkg::*;
(
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_trap_valid,
  input  logic            i_redirect_valid,
  input  logic [PC_W-1:0] i_redirect_target,
  output logic [PC_W-1:0] o_next_pc,
  output logic            o_redirect,
  output logic            o_misalign
);

  // Sequential successor; natural truncation gives the 0xFC -> 0x00 wrap
  logic [PC_W-1:0] w_seq_pc;
  assign w_seq_pc = i_pc + INC;

  // Trap beats redirect; a misaligned redirect is converted into a trap
  always_comb begin
    o_next_pc  = w_seq_pc;
    o_redirect = 1'b0;
    o_misalign = 1'b0;
    if (i_trap_valid) begin
      o_next_pc  = TRAP_VEC;
      o_redirect = 1'b1;
    end else if (i_redirect_valid) begin
      o_redirect = 1'b1;
      if (is_aligned(i_redirect_target)) begin
        o_next_pc = i_redirect_target;
      end else begin
        o_next_pc  = TRAP_VEC;
        o_misalign = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC owner and instruction fetch sequencer
module pc_sequencer
  import pc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt_req,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            trap_valid,
  output logic            fetch_valid,
  output logic [PC_W-1:0] fetch_addr,
  input  logic            fetch_ready,
  input  logic            rsp_valid,
  output logic            issue_valid,
  output logic [PC_W-1:0] issue_pc,
  output logic            misalign_err,
  output logic            running
);

  seq_state_t      r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_req_pc;
  logic            r_pend_valid;
  logic [PC_W-1:0] r_pend_target;
  logic            r_halt_pend;
  logic            r_issue_valid;
  logic [PC_W-1:0] r_issue_pc;
  logic            r_misalign_err;

  logic [PC_W-1:0] w_next_pc;
  logic            w_redirect;
  logic            w_misalign;
  logic            w_fetch_valid;
  logic            w_handshake;

  pc_next_sel u_next_sel (
    .i_pc              (r_pc),
    .i_trap_valid      (trap_valid),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .o_next_pc         (w_next_pc),
    .o_redirect        (w_redirect),
    .o_misalign        (w_misalign)
  );

  // Request is decoded from the registered state and stall only, so the
  // memory's ready never loops back combinationally into fetch_valid
  assign w_fetch_valid = (r_state == REQ) && !stall;
  assign w_handshake   = w_fetch_valid && fetch_ready;

  assign fetch_valid  = w_fetch_valid;
  assign fetch_addr   = r_pc;
  assign running      = (r_state == REQ) || (r_state == WAIT);
  assign issue_valid  = r_issue_valid;
  assign issue_pc     = r_issue_pc;
  assign misalign_err = r_misalign_err;

  // Fetch FSM: PC update, outstanding-request bookkeeping and issue pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_pc           <= RESET_VEC;
      r_req_pc       <= RESET_VEC;
      r_pend_valid   <= 1'b0;
      r_pend_target  <= RESET_VEC;
      r_halt_pend    <= 1'b0;
      r_issue_valid  <= 1'b0;
      r_issue_pc     <= '0;
      r_misalign_err <= 1'b0;
    end else begin
      r_issue_valid  <= 1'b0;
      r_misalign_err <= w_misalign;
      case (r_state)
        IDLE, HALTED: begin
          // Not fetching: control flow changes only move the PC
          if (w_redirect) begin
            r_pc <= w_next_pc;
          end
          if (start) begin
            r_state <= REQ;
          end
        end

        REQ: begin
          if (w_handshake) begin
            r_state  <= WAIT;
            r_req_pc <= r_pc;
            // The request just left; remember the new PC and drop its response
            if (w_redirect) begin
              r_pend_valid  <= 1'b1;
              r_pend_target <= w_next_pc;
            end
            if (halt_req) begin
              r_halt_pend <= 1'b1;
            end
          end else begin
            if (w_redirect) begin
              r_pc <= w_next_pc;
            end
            if (halt_req) begin
              r_state <= HALTED;
            end
          end
        end

        WAIT: begin
          if (halt_req) begin
            r_halt_pend <= 1'b1;
          end
          if (rsp_valid) begin
            if (w_redirect) begin
              // Same-cycle redirect wins over any older pending target
              r_pc <= w_next_pc;
            end else if (r_pend_valid) begin
              r_pc <= r_pend_target;
            end else begin
              r_issue_valid <= 1'b1;
              r_issue_pc    <= r_req_pc;
              r_pc          <= w_next_pc;
            end
            r_pend_valid <= 1'b0;
            r_halt_pend  <= 1'b0;
            r_state      <= (r_halt_pend || halt_req) ? HALTED : REQ;
          end else if (w_redirect) begin
            // Latest redirect while waiting overwrites the pending target
            r_pend_valid  <= 1'b1;
            r_pend_target <= w_next_pc;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side controller for the 8-bit program counter: owns the PC register and sequences instruction fetches over a valid/ready request channel plus a response strobe.
- Selects the next PC: sequential PC+4, branch/jump redirect from execute, or the trap vector.
- Handles stall, halt, and redirects that arrive while a fetch is outstanding.
- Sits between the core control path and the instruction memory port.

Parameters:
- PC_W, 8, PC and address width.
- INC, 4, sequential increment; the PC wraps modulo 2^PC_W.
- RESET_VEC, 8'h00, PC loaded at reset.
- TRAP_VEC, 8'hF0, PC loaded on trap or misaligned redirect.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  leave IDLE/HALTED and begin fetching.
- halt_req  in  1  stop fetching at the next request boundary.
- stall  in  1  suppress new fetch requests.
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  PC_W  redirect destination.
- trap_valid  in  1  exception; has priority over redirect.
- fetch_valid  out  1  fetch request valid.
- fetch_addr  out  PC_W  fetch address; equals pc.
- fetch_ready  in  1  memory accepts the request.
- rsp_valid  in  1  fetch response returned; one per accepted request.
- issue_valid  out  1  registered pulse: a response is accepted and not killed.
- issue_pc  out  PC_W  PC of the issued instruction.
- misalign_err  out  1  registered pulse: redirect target[1:0] != 0.
- running  out  1  state is REQ or WAIT.

Behaviour:
- Reset (async):
  - pc = RESET_VEC, state = IDLE.
  - pend_valid = 0, issue_valid = 0, issue_pc = 0, misalign_err = 0.
  - fetch_valid = 0 and running = 0 while in IDLE.
- States are IDLE, REQ, WAIT, HALTED.
- IDLE/HALTED:
  - start=1 moves to REQ next cycle.
  - A trap or redirect seen in these states updates pc only; state is unchanged.
- REQ:
  - fetch_valid = !stall (registered-state decode only; no combinational path from fetch_ready).
  - fetch_addr = pc.
  - A handshake (fetch_valid && fetch_ready) moves to WAIT and latches req_pc = pc.
  - If halt_req=1 and no handshake this cycle, move to HALTED.
- WAIT:
  - fetch_valid = 0.
  - On rsp_valid with pend_valid=0: issue_valid=1 and issue_pc=req_pc next cycle; pc <= pc + INC (8-bit wrap, 0xFC -> 0x00); return to REQ.
  - On rsp_valid with pend_valid=1: response is killed (no issue_valid); pc <= pend_target; pend_valid <= 0; return to REQ.
- Next-PC priority, highest first: trap_valid -> TRAP_VEC; redirect_valid with misaligned target -> TRAP_VEC plus a misalign_err pulse; redirect_valid -> redirect_target; otherwise sequential.
- A trap or redirect in REQ with no handshake: pc updated next cycle, stay in REQ.
- A trap or redirect in WAIT, or in REQ on the same cycle as a handshake:
  - Store pend_target and set pend_valid=1; the outstanding response will be killed.
  - A later redirect in the same WAIT overwrites pend_target.
- A redirect on the same cycle as rsp_valid in WAIT: the response is killed and the new target is applied directly.
- halt_req during WAIT is held pending; HALTED is entered after the response, never with a fetch outstanding.
- stall does not affect WAIT; a response is always consumed in the cycle rsp_valid is high.
- rsp_valid in IDLE, REQ or HALTED is a protocol error and is ignored (assertion in bench).
- Reset mid-WAIT: everything returns to reset values immediately; a late rsp_valid is ignored.

Decomposition:
- Package pc_pkg contains:
  - typedef pc_t (logic [PC_W-1:0]).
  - enum seq_state_t {IDLE, REQ, WAIT, HALTED}.
  - Constants INC, RESET_VEC, TRAP_VEC.
  - Function is_aligned().
- One sub-module, pc_next_sel: combinational priority mux (trap/redirect/sequential) plus the adder, producing next_pc and the misalign flag.

Test Plan:
- Reset, then start, memory always ready, rsp_valid 2 cycles after each request -> fetch_addr 0x00, 0x04, 0x08; issue_pc follows the same sequence; issue_valid pulses once per response.
- pc=0xFC, sequential response -> next fetch_addr 0x00 (wrap), no error.
- redirect_valid with target 0x40 in WAIT at req_pc=0x10 -> response killed (no issue_valid); next fetch_addr 0x40.
- trap_valid and redirect_valid (0x20) on the same cycle in REQ -> next fetch_addr 0xF0.
- redirect_target 0x22 -> misalign_err pulses 1 cycle; next fetch_addr 0xF0.
- stall=1 for 3 cycles in REQ -> fetch_valid low for those 3 cycles, pc held. Then halt_req during WAIT -> response issued, state HALTED, fetch_valid 0. Then start -> resumes at pc+4.
